// File: rtl/delay_sequencer.sv
// delay_sequencer: arbitrates two level-held delay requests onto one shared
// interval counter and answers each finished delay with a one-cycle done pulse.
`timescale 1ns/1ps

module delay_sequencer #(
    parameter int WIDTH = 12,
    parameter int REP_W = 3
) (
    input  logic             clk_2K,
    input  logic             i_Reset,
    input  logic             i_ReqA,
    input  logic [REP_W-1:0] i_RepA,
    input  logic             i_ReqB,
    input  logic [REP_W-1:0] i_RepB,
    input  logic             i_TwoSec,
    output logic             o_ActCounter,
    output logic             o_RstCounter,
    output logic             o_DoneA,
    output logic             o_DoneB,
    output logic             o_Busy,
    output logic             o_Owner,
    output logic [REP_W-1:0] o_Remaining
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [REP_W-1:0] remaining_q, remaining_d;
    logic             done_a_q, done_a_d;
    logic             done_b_q, done_b_d;
    logic             busy_q, busy_d;

    // Request level of whichever client currently holds the grant.
    logic             owner_req;

    // A requested count of zero still means one interval.
    function automatic logic [REP_W-1:0] norm_count(input logic [REP_W-1:0] rep);
        return (rep == '0) ? REP_W'(1) : rep;
    endfunction

    // Select the owning client's request so abort/release follow the grant.
    always_comb begin
        owner_req = owner_q ? i_ReqB : i_ReqA;
    end

    // Next-state logic: grant with fixed A priority, count intervals, abort on drop.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (i_ReqA) begin
                    owner_d     = 1'b0;
                    remaining_d = norm_count(i_RepA);
                    state_d     = S_CLEAR;
                end else if (i_ReqB) begin
                    owner_d     = 1'b1;
                    remaining_d = norm_count(i_RepB);
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!owner_req) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!owner_req) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (i_TwoSec) begin
                    if (remaining_q == REP_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        remaining_d = remaining_q - REP_W'(1);
                        state_d     = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // The grant is held until the owner lets go; the other client waits.
                if (!owner_req) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // Registered status outputs are computed from the upcoming state.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_a_d = (state_d == S_DONE) && !owner_d;
        done_b_d = (state_d == S_DONE) &&  owner_d;
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk_2K or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            remaining_q <= '0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            busy_q      <= busy_d;
        end
    end

    // Counter controls decode straight from the state; the counter only runs in RUN.
    always_comb begin
        o_ActCounter = 1'b0;
        o_RstCounter = 1'b1;
        if (state_q == S_RUN) begin
            o_ActCounter = 1'b1;
            o_RstCounter = 1'b0;
        end
    end

    assign o_DoneA     = done_a_q;
    assign o_DoneB     = done_b_q;
    assign o_Busy      = busy_q;
    assign o_Owner     = owner_q;
    assign o_Remaining = remaining_q;

`ifndef SYNTHESIS
    // Length of the current RUN stretch; the counter saturates after 2^WIDTH cycles.
    logic [WIDTH:0] run_len_q, run_len_d;

    // Count consecutive RUN cycles, restarting whenever RUN is left.
    always_comb begin
        run_len_d = '0;
        if (state_q == S_RUN && run_len_q != '1) begin
            run_len_d = run_len_q + (WIDTH+1)'(1);
        end
    end

    // Run-length register for the interval sanity check.
    always_ff @(posedge clk_2K or negedge i_Reset) begin
        if (!i_Reset) begin
            run_len_q <= '0;
        end else begin
            run_len_q <= run_len_d;
        end
    end

    a_act_rst_exclusive: assert property (@(posedge clk_2K) disable iff (!i_Reset)
        !(o_ActCounter && o_RstCounter));
    a_done_exclusive: assert property (@(posedge clk_2K) disable iff (!i_Reset)
        !(o_DoneA && o_DoneB));
    a_run_bounded: assert property (@(posedge clk_2K) disable iff (!i_Reset)
        (state_q == S_RUN) |-> (run_len_q < (WIDTH+1)'(2**WIDTH)));
`endif

endmodule
